// File: rtl/line_mem_ctrl.sv
// Registered controller between the CPU's 256-bit line port and a single-port block RAM of 32-byte lines.
// Handles emulated wait states, RAM read latency, out-of-range detection and the CPU mem_wait handshake.
module line_mem_ctrl #(
  parameter int ADDR_W      = 6,
  parameter int RD_LATENCY  = 1,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [255:0]      mem_wdata_in,
  input  logic [31:0]       mem_be_in,
  input  logic              stall_in,
  output logic [255:0]      mem_rdata_out,
  output logic              mem_wait_out,
  output logic              busy_out,
  output logic              err_out,
  output logic              bram_en,
  output logic [31:0]       bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [255:0]      bram_din,
  input  logic [255:0]      bram_dout
);

  typedef enum logic [2:0] {IDLE, WAITST, ACCESS, LAT, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [1:0] LAT_LOAD  = 2'(RD_LATENCY - 1);

  // Handshake: the CPU raises mem_req_in and holds address/data stable while
  // mem_wait_out is high; the cycle with mem_wait_out low (DONE) completes it.
  state_t        state, state_nxt;
  logic [31:5]   addr_q;
  logic          we_q;
  logic [255:0]  wdata_q;
  logic [31:0]   be_q;
  logic [3:0]    wait_cnt;
  logic [1:0]    lat_cnt;
  logic          accept;
  logic [31:5]   addr_sel;
  logic          we_sel;
  logic [255:0]  wdata_sel;
  logic [31:0]   be_sel;
  logic          oor_sel;
  logic          oor_q;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^mem_addr_in[4:0];

  assign accept = (state == IDLE) && mem_req_in && !stall_in;

  // When ACCESS follows IDLE directly the request registers are still loading,
  // so the RAM port is fed from the live inputs in that case.
  assign addr_sel  = (state == IDLE) ? mem_addr_in[31:5] : addr_q;
  assign we_sel    = (state == IDLE) ? mem_we_in         : we_q;
  assign wdata_sel = (state == IDLE) ? mem_wdata_in      : wdata_q;
  assign be_sel    = (state == IDLE) ? mem_be_in         : be_q;
  assign oor_sel   = |addr_sel[31:ADDR_W+5];
  assign oor_q     = |addr_q[31:ADDR_W+5];

  assign busy_out = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    mem_wait_out = 1'b1;
    case (state)
      IDLE: begin
        mem_wait_out = mem_req_in;
        if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAITST : ACCESS;
      end
      WAITST: if (!stall_in && wait_cnt == 4'd0) state_nxt = ACCESS;
      ACCESS: state_nxt = we_q ? DONE : LAT;
      LAT:    if (lat_cnt == 2'd0) state_nxt = DONE;
      DONE: begin
        mem_wait_out = 1'b0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      be_q          <= '0;
      wait_cnt      <= '0;
      lat_cnt       <= '0;
      mem_rdata_out <= '0;
      err_out       <= 1'b0;
      bram_en       <= 1'b0;
      bram_we       <= '0;
      bram_addr     <= '0;
      bram_din      <= '0;
    end else begin
      // RAM strobes are registered so they are asserted exactly during ACCESS.
      bram_en <= (state_nxt == ACCESS);
      bram_we <= '0;
      if (state_nxt == ACCESS) begin
        bram_addr <= addr_sel[ADDR_W+4:5];
        bram_din  <= wdata_sel;
        if (we_sel && !oor_sel) bram_we <= be_sel;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= mem_addr_in[31:5];
            we_q     <= mem_we_in;
            wdata_q  <= mem_wdata_in;
            be_q     <= mem_be_in;
            wait_cnt <= WAIT_LOAD;
          end
        end
        WAITST: begin
          if (!stall_in && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        ACCESS: begin
          lat_cnt <= LAT_LOAD;
          if (oor_q) err_out <= 1'b1;
        end
        LAT: begin
          if (lat_cnt == 2'd0) mem_rdata_out <= oor_q ? '0 : bram_dout;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
